// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel programmable timer.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int CLK_PER_MS = 180000;

    // Only these two modes make a channel count; reserved decodes as stop.
    function automatic logic mode_runs(input mode_e m);
        return (m == MODE_ONESHOT) || (m == MODE_PERIODIC);
    endfunction

endpackage

// File: rtl/multi_timer_timer_chan.sv
// One timer channel: latched period, down-counter, mode and registered tick/sig/busy.
module timer_chan
    import multi_timer_pkg::*;
#(
    parameter int               CNT_W      = 28,
    parameter logic [CNT_W-1:0] RST_PERIOD = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             wr_i,
    input  mode_e            mode_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o,
    output logic             sig_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    mode_e            mode_q,   mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             tick_q,   tick_d;
    logic             sig_q,    sig_d;

    // A write on the expiry edge takes priority and suppresses that tick.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        sig_d    = sig_q;
        tick_d   = 1'b0;
        if (wr_i) begin
            if (mode_runs(mode_i) && (period_i != '0)) begin
                mode_d   = mode_i;
                period_d = period_i;
                cnt_d    = period_i - ONE;
                busy_d   = 1'b1;
            end else begin
                mode_d = MODE_STOP;
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                tick_d = 1'b1;
                sig_d  = ~sig_q;
                if (mode_q == MODE_PERIODIC) cnt_d  = period_q - ONE;
                else                         busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_q   <= MODE_STOP;
            period_q <= RST_PERIOD;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            sig_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            sig_q    <= sig_d;
        end
    end

    assign tick_o = tick_q;
    assign sig_o  = sig_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/multi_timer.sv
// CH-channel programmable timer: config decode and ready here, per-channel state in timer_chan.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CNT_W      = 28,
    parameter int CLK_PER_MS = multi_timer_pkg::CLK_PER_MS,
    localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    output logic [CH-1:0]    tick_out,
    output logic [CH-1:0]    sig_out,
    output logic [CH-1:0]    busy_out
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(1000 * CLK_PER_MS);

    logic ready_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign cfg_ready = ready_q;

    // Indices with no channel behind them match nothing, so such writes vanish.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_valid & ready_q & (cfg_ch == CHW'(i));

        timer_chan #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .wr_i     (wr),
            .mode_i   (mode_e'(cfg_mode)),
            .period_i (cfg_period),
            .tick_o   (tick_out[i]),
            .sig_o    (sig_out[i]),
            .busy_o   (busy_out[i])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed checks of multi_timer with CH=3 (non-power-of-2 channel count).
module tb_multi_timer;
    import multi_timer_pkg::*;

    localparam int CH    = 3;
    localparam int CNT_W = 28;
    localparam int CHW   = 2;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CH-1:0]    tick_out, sig_out, busy_out;

    int n_chk  = 0;
    int n_fail = 0;

    multi_timer #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .tick_out   (tick_out),
        .sig_out    (sig_out),
        .busy_out   (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Advance past the next rising edge; samples and drives land 1 time unit later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input int ch, input mode_e m, input int p);
        cfg_valid  = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_mode   = m;
        cfg_period = CNT_W'(p);
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_tick",  32'(tick_out), 32'd0);
        chk("rst_sig",   32'(sig_out),  32'd0);
        chk("rst_busy",  32'(busy_out), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        rst_in = 1'b0;
        #1;
        chk("ready_pre_edge", 32'(cfg_ready), 32'd0);
        step();
        chk("ready_post_edge", 32'(cfg_ready), 32'd1);

        // PERIODIC ch0 P=5
        wr(0, MODE_PERIODIC, 5);
        chk("p5_busy", 32'(busy_out[0]), 32'd1);
        chk("p5_tick0", 32'(tick_out[0]), 32'd0);
        for (int j = 1; j <= 20; j++) begin
            step();
            chk("p5_tick", 32'(tick_out[0]), 32'((j % 5) == 0));
            chk("p5_sig",  32'(sig_out[0]),  32'((j / 5) % 2));
        end
        wr(0, MODE_STOP, 0);
        chk("p5_stop_busy", 32'(busy_out[0]), 32'd0);
        chk("p5_stop_sig",  32'(sig_out[0]),  32'd0);

        // ONESHOT ch1 P=3
        wr(1, MODE_ONESHOT, 3);
        chk("os_busy0", 32'(busy_out[1]), 32'd1);
        for (int j = 1; j <= 8; j++) begin
            step();
            chk("os_tick", 32'(tick_out[1]), 32'(j == 3));
            chk("os_busy", 32'(busy_out[1]), 32'(j < 3));
            chk("os_sig",  32'(sig_out[1]),  32'(j >= 3));
        end

        // P=1 PERIODIC ch2, then P=0 stops it on what would be an expiry edge
        wr(2, MODE_PERIODIC, 1);
        chk("p1_tick0", 32'(tick_out[2]), 32'd0);
        chk("p1_busy0", 32'(busy_out[2]), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("p1_tick", 32'(tick_out[2]), 32'd1);
            chk("p1_sig",  32'(sig_out[2]),  32'(j % 2));
        end
        wr(2, MODE_PERIODIC, 0);
        chk("p0_tick", 32'(tick_out[2]), 32'd0);
        chk("p0_busy", 32'(busy_out[2]), 32'd0);
        chk("p0_sig",  32'(sig_out[2]),  32'd0);
        step();
        chk("p0_tick_after", 32'(tick_out[2]), 32'd0);

        // Rewrite ch0 on its expiry edge
        wr(0, MODE_PERIODIC, 4);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("rw_pre_tick", 32'(tick_out[0]), 32'd0);
        end
        wr(0, MODE_PERIODIC, 6);
        chk("rw_edge_tick", 32'(tick_out[0]), 32'd0);
        chk("rw_edge_sig",  32'(sig_out[0]),  32'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("rw_tick", 32'(tick_out[0]), 32'(j == 6));
            chk("rw_sig",  32'(sig_out[0]),  32'(j == 6));
        end

        // Out-of-range channel write alongside running ch0 (P=2) and ch1 (P=3)
        wr(0, MODE_PERIODIC, 2);
        wr(1, MODE_PERIODIC, 3);
        wr(3, MODE_PERIODIC, 1);
        for (int t = 2; t <= 13; t++) begin
            if (t > 2) step();
            chk("oor_tick", 32'(tick_out),
                32'({1'b0, (t >= 4) && ((t - 4) % 3 == 0), (t % 2) == 0}));
            chk("oor_busy", 32'(busy_out), 32'b011);
        end

        // Reset mid-count clears everything without waiting for an edge
        rst_in = 1'b1;
        #1;
        chk("mid_rst_tick",  32'(tick_out),  32'd0);
        chk("mid_rst_sig",   32'(sig_out),   32'd0);
        chk("mid_rst_busy",  32'(busy_out),  32'd0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
        step(); step();
        rst_in = 1'b0;
        step();
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);
        chk("post_rst_busy",  32'(busy_out),  32'd0);
        step(); step();
        chk("post_rst_tick",  32'(tick_out),  32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
